block_matcher: RTL and testbench
================================

// Module: block_matcher
// PURPOSE
//   Downstream of the serial 128-bit block collector. Accepts one assembled 128-bit block
//   per valid/ready handshake and compares it, one entry per cycle, against a fixed table
//   of prestored test keys. Reports hit/miss, the index of the first matching entry, and a
//   saturating hit counter. The table holds constants for bring-up only.
// PARAMETERS
//   WIDTH        128  block width in bits
//   NUM_ENTRIES  4    number of prestored entries (>=1)
//   IDX_W        2    width of entry index, clog2(NUM_ENTRIES), minimum 1
//   CNT_W        16   width of hit counter
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous active-low reset
//   blk_valid    in   1          assembled block available (collector end-of-sequence strobe)
//   blk_data     in   WIDTH      assembled block, sampled only on accept
//   blk_ready    out  1          block can be accepted this cycle
//   busy         out  1          comparison in progress
//   done         out  1          one-cycle pulse: result valid
//   match        out  1          last result was a hit; held until next accept
//   match_idx    out  IDX_W      first matching entry index; 0 on miss; held
//   hit_count    out  CNT_W      number of hits since reset, saturates at all ones
// BEHAVIOUR
//   Table (entry: value):
//     0: 128'h0123456789ABCDEF_FEDCBA9876543210
//     1: 128'hDEADBEEFCAFEBABE_0BADF00DFEEDFACE
//     2: 128'h0
//     3: 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF
//   Reset (async, rst_n low): state=IDLE, blk_ready=1, busy=0, done=0, match=0,
//     match_idx=0, hit_count=0, captured block=0, idx=0.
//   FSM states IDLE, COMPARE, REPORT (all outputs registered):
//   IDLE: blk_ready=1. Accept = blk_valid & blk_ready at an edge: capture blk_data, idx=0,
//     clear match/match_idx, go COMPARE. blk_valid while not ready is ignored (not queued).
//   COMPARE: blk_ready=0, busy=1. Each cycle, full WIDTH equality of captured block vs table[idx].
//     Equal: match=1, match_idx=idx, hit_count+1 (saturating), go REPORT.
//     Not equal and idx==NUM_ENTRIES-1: match=0, match_idx=0, go REPORT.
//     Otherwise idx+1, stay COMPARE.
//   REPORT: done=1 for exactly this cycle, busy=0, blk_ready=0; next edge -> IDLE.
//   Latency: hit on entry i -> done high i+1 cycles after the accept edge; miss -> done
//     NUM_ENTRIES cycles after accept. Next accept earliest one edge after done falls,
//     i.e. back-to-back period = latency + 2 cycles.
//   Duplicate entries: lowest index wins (search stops at first hit).
//   hit_count at all ones: a further hit leaves it unchanged.
//   rst_n asserted mid-COMPARE/REPORT: immediate return to reset values, no done issued,
//     in-flight block discarded; hit_count cleared.
//   blk_data changing after accept has no effect on the in-flight result.
// TESTING
//   1 Reset: rst_n low then high -> blk_ready=1, done=0, match=0, match_idx=0, hit_count=0.
//   2 Hit entry 0: accept 128'h0123..3210 -> done one cycle after accept edge, match=1,
//     match_idx=0, hit_count=1; blk_ready low until one cycle after done.
//   3 Hit entry 3 (all ones) -> done 4 cycles after accept, match=1, match_idx=3; then a miss
//     128'h1 -> done 4 cycles after accept, match=0, match_idx=0, hit_count unchanged.
//   4 Back-to-back: blk_valid held high with entry 2 then entry 1; second block accepted
//     exactly on the cycle blk_ready returns; blk_data changes while busy ignored.
//   5 Reset mid-operation: assert rst_n low 1 cycle after accepting a miss block -> no done
//     pulse, all outputs at reset values, next accept behaves as test 2.
//   6 Saturation: force/run CNT_W=2 with 5 hits -> hit_count sticks at 2'b11.

Source files
------------

// File: rtl/block_matcher.sv
// block_matcher: compares each accepted block against a constant key table, one entry per cycle
module block_matcher #(
  parameter int WIDTH       = 128,
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  input  logic [WIDTH-1:0] blk_data,
  output logic             blk_ready,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [IDX_W-1:0] match_idx,
  output logic [CNT_W-1:0] hit_count
);
  typedef enum logic [1:0] {IDLE, COMPARE, REPORT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] blk;
  logic [IDX_W-1:0] idx;
  logic accept, hit, last;
  function automatic logic [WIDTH-1:0] entry(input int i);
    case (i)
      0:       entry = WIDTH'(128'h0123456789ABCDEF_FEDCBA9876543210);
      1:       entry = WIDTH'(128'hDEADBEEFCAFEBABE_0BADF00DFEEDFACE);
      3:       entry = WIDTH'(128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF);
      default: entry = '0;
    endcase
  endfunction
  assign accept = blk_valid & blk_ready;
  assign hit    = blk == entry(int'(idx));
  assign last   = idx == IDX_W'(NUM_ENTRIES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE)    ? (accept ? COMPARE : IDLE) :
                (state == COMPARE) ? ((hit | last) ? REPORT : COMPARE) : IDLE;
  // Flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blk_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      match_idx <= '0;
      hit_count <= '0;
      blk       <= '0;
      idx       <= '0;
    end else begin
      blk_ready <= state_nxt == IDLE;
      busy      <= state_nxt == COMPARE;
      done      <= state_nxt == REPORT;
      if (accept) begin
        blk       <= blk_data;
        idx       <= '0;
        match     <= 1'b0;
        match_idx <= '0;
      end else if (state == COMPARE) begin
        if (hit) begin
          match     <= 1'b1;
          match_idx <= idx;
          hit_count <= &hit_count ? hit_count : hit_count + CNT_W'(1);
        end else if (last) begin
          match     <= 1'b0;
          match_idx <= '0;
        end else idx <= idx + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_block_matcher.sv
// tb_block_matcher: directed checks of the key matcher, plus a 2-bit counter instance for saturation
module tb_block_matcher;
  localparam logic [127:0] K0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K1 = 128'hDEADBEEFCAFEBABE_0BADF00DFEEDFACE;
  localparam logic [127:0] K2 = 128'h0;
  localparam logic [127:0] K3 = {128{1'b1}};
  logic clk = 1'b0, rst_n = 1'b0, blk_valid = 1'b0, sat_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic blk_ready, busy, done, match;
  logic [1:0] match_idx;
  logic [15:0] hit_count;
  logic sat_ready, sat_busy, sat_done, sat_match;
  logic [1:0] sat_idx, sat_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  block_matcher dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(blk_ready), .busy(busy), .done(done), .match(match),
    .match_idx(match_idx), .hit_count(hit_count)
  );
  block_matcher #(.CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .blk_valid(sat_valid), .blk_data(blk_data),
    .blk_ready(sat_ready), .busy(sat_busy), .done(sat_done), .match(sat_match),
    .match_idx(sat_idx), .hit_count(sat_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  // One transaction: accept, check done stays low for lat-1 cycles, then result and ready return.
  task automatic run(input logic [127:0] d, input int lat, input logic m, input logic [1:0] mi, input int cnt);
    blk_data  = d;
    blk_valid = 1'b1;
    tick;
    blk_valid = 1'b0;
    check("accept_ready", blk_ready, 0);
    check("accept_busy", busy, 1);
    for (int k = 1; k < lat; k++) begin
      tick;
      check("early_done", done, 0);
    end
    tick;
    check("done", done, 1);
    check("busy_report", busy, 0);
    check("ready_report", blk_ready, 0);
    check("match", match, m);
    check("match_idx", match_idx, mi);
    check("hit_count", hit_count, cnt);
    tick;
    check("done_pulse", done, 0);
    check("ready_back", blk_ready, 1);
    check("match_held", match, m);
  endtask
  initial begin
    repeat (2) tick;
    check("rst_ready_low", blk_ready, 1);
    rst_n = 1'b1;
    tick;
    check("rst_ready", blk_ready, 1);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_idx", match_idx, 0);
    check("rst_count", hit_count, 0);
    run(K0, 1, 1'b1, 2'd0, 1);
    run(K3, 4, 1'b1, 2'd3, 2);
    run(128'h1, 4, 1'b0, 2'd0, 2);
    // back-to-back with valid held and data changed while busy
    blk_data  = K2;
    blk_valid = 1'b1;
    tick;
    check("b2b_busy", busy, 1);
    blk_data = K3;
    tick;
    tick;
    blk_data = K1;
    tick;
    check("b2b_done1", done, 1);
    check("b2b_idx1", match_idx, 2);
    check("b2b_cnt1", hit_count, 3);
    tick;
    check("b2b_idle_ready", blk_ready, 1);
    check("b2b_idle_busy", busy, 0);
    tick;
    blk_valid = 1'b0;
    check("b2b_accept2", busy, 1);
    tick;
    check("b2b_early", done, 0);
    blk_data = K0;
    tick;
    check("b2b_done2", done, 1);
    check("b2b_match2", match, 1);
    check("b2b_idx2", match_idx, 1);
    check("b2b_cnt2", hit_count, 4);
    tick;
    // reset one cycle into a miss
    blk_data  = 128'h5;
    blk_valid = 1'b1;
    tick;
    blk_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", blk_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", hit_count, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("mid_rst_done", done, 0);
    end
    rst_n = 1'b1;
    tick;
    check("post_rst_match", match, 0);
    run(K0, 1, 1'b1, 2'd0, 1);
    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      blk_data  = K0;
      sat_valid = 1'b1;
      tick;
      sat_valid = 1'b0;
      tick;
      check("sat_done", sat_done, 1);
      check("sat_count", sat_count, (i < 3) ? i + 1 : 3);
      tick;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
